fft_bfly_addr_gen: RTL

Control and address generator for the radix-4 butterfly stages of the FFT pipeline, directly downstream of the stage-1 input loader. It starts on the loader's start pulse and runs NumStages in-place passes over the four data SRAM banks. Each pass reads one word per bank per cycle and writes butterfly results back to the same addresses after the datapath latency. When all passes finish, it raises a level that tells the loader to switch into unload (stage-3) mode.

---
 rtl/fft_pkg.sv | 50 +++++
 rtl/fft_delay_line.sv | 40 ++++
 rtl/fft_bfly_addr_gen.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: butterfly-controller state encoding, default
// geometry constants shared with the input loader, and the address
// rotation helper used for the radix-4 stage permutation.
package fft_pkg;

    // Default SRAM bank address width and butterfly datapath latency.
    localparam int unsigned AddrWidth   = 7;
    localparam int unsigned BflyLatency = 4;

    // Widest bank address the rotation helper supports.
    localparam int unsigned AddrMax  = 16;
    localparam int unsigned AddrIdxW = $clog2(AddrMax);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } bfly_state_e;

    // Rotate the low 'width' bits of addr left by (amt mod width).
    // Bits at and above 'width' come back as zero.
    function automatic logic [AddrMax-1:0] rotl_addr(
        input logic [AddrMax-1:0] addr,
        input int unsigned        amt,
        input int unsigned        width = AddrWidth
    );
        logic [AddrMax-1:0]  res;
        logic [AddrIdxW-1:0] dst;
        int unsigned         sh;
        res = '0;
        dst = '0;
        if (width == 32'd0) begin
            sh = 32'd0;
        end else begin
            sh = amt % width;
        end
        for (int unsigned i = 0; i < AddrMax; i++) begin
            if (i < width) begin
                dst      = AddrIdxW'((i + sh) % width);
                res[dst] = addr[i];
            end else begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth register pipeline. Every stage is cleared by reset only;
// it carries the {valid, address} pair from the read port to write-back.
module fft_delay_line #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] pipe_q [Depth];
    logic [Width-1:0] pipe_d [Depth];

    // Shift: new word enters stage 0, each stage takes its predecessor.
    always_comb begin
        pipe_d[0] = d_i;
        for (int unsigned i = 1; i < Depth; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipeline storage; an asynchronous reset empties it at once so no
    // stale write can leave after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/fft_bfly_addr_gen.sv
// Radix-4 butterfly pass controller. Runs NumStages in-place passes over
// four SRAM banks: each pass reads every address once (all banks in
// parallel) and writes the butterfly result back to the same address
// BflyLatency+1 cycles later. Signals the loader when results are ready.
module fft_bfly_addr_gen #(
    parameter int unsigned  AddrWidth   = fft_pkg::AddrWidth,
    parameter int unsigned  NumStages   = 3,
    parameter int unsigned  BflyLatency = fft_pkg::BflyLatency,
    localparam int unsigned StageW      = $clog2(NumStages) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 stage2_o,
    output logic [StageW-1:0]    stage_o,
    output logic [3:0]           ren_o,
    output logic [AddrWidth-1:0] addr_rd_o,
    output logic [AddrWidth-1:0] tw_addr_o,
    output logic                 bfly_valid_o,
    output logic [3:0]           wen_o,
    output logic [AddrWidth-1:0] addr_wr_o
);

    import fft_pkg::*;

    // One counter serves both the read sweep and the drain interval.
    localparam int unsigned       NumWords  = 1 << AddrWidth;
    localparam int unsigned       DrainW    = $clog2(BflyLatency + 2);
    localparam int unsigned       CntW      = (AddrWidth > DrainW) ? AddrWidth : DrainW;
    localparam logic [CntW-1:0]   CntLast   = CntW'(NumWords - 1);
    localparam logic [CntW-1:0]   DrainLast = CntW'(BflyLatency);
    localparam logic [StageW-1:0] StageLast = StageW'(NumStages - 1);

    bfly_state_e state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [StageW-1:0] stage_q, stage_d;

    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 stage2_q, stage2_d;
    logic [3:0]           ren_q, ren_d;
    logic [AddrWidth-1:0] addr_rd_q, addr_rd_d;
    logic [AddrWidth-1:0] tw_addr_q, tw_addr_d;
    logic                 bfly_valid_q, bfly_valid_d;

    logic [AddrWidth-1:0] rd_idx_s;
    int unsigned          shamt_s;
    logic [AddrWidth:0]   wb_in_s;
    logic [AddrWidth:0]   wb_out_s;

    // State, sweep counter and pass index registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            stage_q <= stage_d;
        end
    end

    // Next-state logic: sweep R reads, drain the write-back pipe, then
    // either advance to the next pass or finish.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        stage_d = stage_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_READ;
                    count_d = '0;
                    stage_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (count_q == CntLast) begin
                    state_d = ST_DRAIN;
                    count_d = '0;
                end else begin
                    count_d = count_q + CntW'(1);
                end
            end
            ST_DRAIN: begin
                if (count_q == DrainLast) begin
                    count_d = '0;
                    if (stage_q == StageLast) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end else begin
                    count_d = count_q + CntW'(1);
                end
            end
            ST_NEXT: begin
                state_d = ST_READ;
                count_d = '0;
                stage_d = stage_q + StageW'(1);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
                stage_d = '0;
            end
        endcase
    end

    // Output decode from the next state so every port comes straight
    // off a flop yet lines up with the state it describes.
    always_comb begin
        rd_idx_s     = count_d[AddrWidth-1:0];
        shamt_s      = 32'(stage_d) * 32'd2;
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        bfly_valid_d = ren_q[0];
        if (state_d == ST_READ) begin
            ren_d     = 4'hF;
            addr_rd_d = AddrWidth'(rotl_addr(AddrMax'(rd_idx_s), shamt_s, AddrWidth));
            tw_addr_d = rd_idx_s << shamt_s;
        end else begin
            ren_d     = 4'h0;
            addr_rd_d = '0;
            tw_addr_d = '0;
        end
        // Results-ready level: set on completion, dropped once a new
        // run is accepted, otherwise held (including through IDLE).
        if (state_d == ST_DONE) begin
            stage2_d = 1'b1;
        end else if ((state_q == ST_IDLE) && start_i) begin
            stage2_d = 1'b0;
        end else begin
            stage2_d = stage2_q;
        end
    end

    // Registered output stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            stage2_q     <= 1'b0;
            ren_q        <= 4'h0;
            addr_rd_q    <= '0;
            tw_addr_q    <= '0;
            bfly_valid_q <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            stage2_q     <= stage2_d;
            ren_q        <= ren_d;
            addr_rd_q    <= addr_rd_d;
            tw_addr_q    <= tw_addr_d;
            bfly_valid_q <= bfly_valid_d;
        end
    end

    // Each issued read travels down the pipe and emerges as exactly one
    // write to the same address BflyLatency+1 cycles later.
    assign wb_in_s = {ren_q[0], addr_rd_q};

    fft_delay_line #(
        .Width (AddrWidth + 1),
        .Depth (BflyLatency + 1)
    ) u_wb_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (wb_in_s),
        .q_o    (wb_out_s)
    );

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign stage2_o     = stage2_q;
    assign stage_o      = stage_q;
    assign ren_o        = ren_q;
    assign addr_rd_o    = addr_rd_q;
    assign tw_addr_o    = tw_addr_q;
    assign bfly_valid_o = bfly_valid_q;
    assign wen_o        = {4{wb_out_s[AddrWidth]}};
    assign addr_wr_o    = wb_out_s[AddrWidth-1:0];

endmodule
